// File: rtl/freq_counter_pkg.sv
// Shared types and constants for the BCD frequency counter: seven-segment
// encodings (active-high, bit0=a .. bit6=g), the BCD digit type and the gate-period floor.
package freq_counter_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // A one-cycle window would make the terminal cycle permanent.
  localparam int PERIOD_MIN = 2;

  function automatic logic [6:0] seg_encode(input bcd_digit_t d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/segment_scanner.sv
// Multiplexes the display digits onto one seven-segment bus: one digit per
// SCAN_CYCLES clocks, leading-zero blanking, registered decode aligned with digit_sel.
module segment_scanner
  import freq_counter_pkg::*;
#(
  parameter int DIGITS        = 3,
  parameter int SCAN_CYCLES   = 64,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   digits,
  output logic [6:0]            segments,
  output logic [DIGITS-1:0]     digit_sel
);

  localparam int                SCAN_W    = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);

  logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [DIGITS-1:0] digit_sel_q, digit_sel_d;
  logic [6:0]        segments_q, segments_d;
  logic [DIGITS-1:0] blank;
  bcd_digit_t        sel_digit;
  logic              sel_blank;

  // A digit is blank when it and everything above it are zero; digit 0 always shows.
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    blank      = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above & (digits[4*i +: 4] == 4'd0);
      blank[i]   = BLANK_LEADING && (i != 0) && zero_above;
    end
  end

  // Decode is taken from the next selection so digit_sel and segments move together.
  always_comb begin
    scan_cnt_d  = scan_cnt_q + 1'b1;
    digit_sel_d = digit_sel_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d  = '0;
      digit_sel_d = (digit_sel_q << 1) | (digit_sel_q >> (DIGITS - 1));
    end
    sel_digit = '0;
    sel_blank = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (digit_sel_d[i]) begin
        sel_digit = digits[4*i +: 4];
        sel_blank = blank[i];
      end
    end
    segments_d = sel_blank ? SEG_BLANK : seg_encode(sel_digit);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt_q  <= '0;
      digit_sel_q <= DIGITS'(1);
      segments_q  <= SEG_0;
    end else begin
      scan_cnt_q  <= scan_cnt_d;
      digit_sel_q <= digit_sel_d;
      segments_q  <= segments_d;
    end
  end

  assign segments  = segments_q;
  assign digit_sel = digit_sel_q;

endmodule

// File: rtl/bcd_frequency_counter.sv
// Gated frequency counter: counts rising edges of an asynchronous pin over a
// loadable window of clocks directly in saturating BCD and shows the last result.
module bcd_frequency_counter
  import freq_counter_pkg::*;
#(
  parameter int DIGITS         = 3,
  parameter int PERIOD_BITS    = 16,
  parameter int DEFAULT_PERIOD = 1200,
  parameter int SCAN_CYCLES    = 64,
  parameter bit BLANK_LEADING  = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   signal,
  input  logic [PERIOD_BITS-1:0] period,
  input  logic                   period_load,
  output logic [6:0]             segments,
  output logic [DIGITS-1:0]      digit_sel,
  output logic                   overflow,
  output logic                   valid
);

  localparam int                     ACC_W        = 4 * DIGITS;
  localparam logic [PERIOD_BITS-1:0] PERIOD_RST   = PERIOD_BITS'(DEFAULT_PERIOD);
  localparam logic [PERIOD_BITS-1:0] PERIOD_FLOOR = PERIOD_BITS'(PERIOD_MIN);

  logic                   sync1_q, sync2_q, sync3_q;
  logic [PERIOD_BITS-1:0] gate_cnt_q, gate_cnt_d;
  logic [PERIOD_BITS-1:0] period_q, period_d;
  logic [ACC_W-1:0]       acc_q, acc_d, acc_inc;
  logic [ACC_W-1:0]       disp_q, disp_d;
  logic                   sat_q, sat_d, sat_next;
  logic                   overflow_q, overflow_d;
  logic                   valid_q, valid_d;
  logic                   detect, tc, all_nines;

  assign detect = sync2_q & ~sync3_q;
  assign tc     = (gate_cnt_q == period_q - 1'b1);

  // Decimal ripple increment; once every digit is 9 the pulse is dropped.
  always_comb begin
    logic carry;
    all_nines = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      all_nines = all_nines & (acc_q[4*i +: 4] == 4'd9);
    end
    carry   = detect & ~all_nines;
    acc_inc = acc_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (acc_q[4*i +: 4] == 4'd9) begin
          acc_inc[4*i +: 4] = 4'd0;
        end else begin
          acc_inc[4*i +: 4] = acc_q[4*i +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
    end
    sat_next = sat_q | (detect & all_nines);
  end

  // NOTE: every signal driven here gets a default first, so no latch is inferred.
  always_comb begin
    period_d   = period_q;
    gate_cnt_d = tc ? '0 : gate_cnt_q + 1'b1;
    acc_d      = acc_inc;
    sat_d      = sat_next;
    disp_d     = disp_q;
    overflow_d = overflow_q;
    valid_d    = 1'b0;
    if (period_load) begin
      // Load beats TC: the partial window is thrown away and nothing is published.
      period_d   = (period < PERIOD_FLOOR) ? PERIOD_FLOOR : period;
      gate_cnt_d = '0;
      acc_d      = '0;
      sat_d      = 1'b0;
    end else if (tc) begin
      disp_d     = acc_inc;
      overflow_d = sat_next;
      valid_d    = 1'b1;
      acc_d      = '0;
      sat_d      = 1'b0;
    end
  end

  // NOTE: non-blocking assignments make every flop sample pre-edge values,
  // which is what lets the synchroniser chain shift by exactly one stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      sync3_q    <= 1'b0;
      gate_cnt_q <= '0;
      period_q   <= PERIOD_RST;
      acc_q      <= '0;
      sat_q      <= 1'b0;
      disp_q     <= '0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      sync1_q    <= signal;
      sync2_q    <= sync1_q;
      sync3_q    <= sync2_q;
      gate_cnt_q <= gate_cnt_d;
      period_q   <= period_d;
      acc_q      <= acc_d;
      sat_q      <= sat_d;
      disp_q     <= disp_d;
      overflow_q <= overflow_d;
      valid_q    <= valid_d;
    end
  end

  assign overflow = overflow_q;
  assign valid    = valid_q;

  segment_scanner #(
    .DIGITS        (DIGITS),
    .SCAN_CYCLES   (SCAN_CYCLES),
    .BLANK_LEADING (BLANK_LEADING)
  ) u_scanner (
    .clk       (clk),
    .reset     (reset),
    .digits    (disp_q),
    .segments  (segments),
    .digit_sel (digit_sel)
  );

endmodule

// File: tb/tb_bcd_frequency_counter.sv
// Directed bench for bcd_frequency_counter: a table of whole-window counts plus
// hand-written sequences for TC-edge, mid-window load, clamp and mid-run reset.
module tb_bcd_frequency_counter;

  localparam int DIGITS         = 3;
  localparam int PERIOD_BITS    = 16;
  localparam int DEFAULT_PERIOD = 120;
  localparam int SCAN_CYCLES    = 4;

  logic                   clk         = 1'b0;
  logic                   reset       = 1'b1;
  logic                   signal      = 1'b0;
  logic [PERIOD_BITS-1:0] period      = '0;
  logic                   period_load = 1'b0;
  logic [6:0]             segments;
  logic [DIGITS-1:0]      digit_sel;
  logic                   overflow;
  logic                   valid;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  bcd_frequency_counter #(
    .DIGITS         (DIGITS),
    .PERIOD_BITS    (PERIOD_BITS),
    .DEFAULT_PERIOD (DEFAULT_PERIOD),
    .SCAN_CYCLES    (SCAN_CYCLES),
    .BLANK_LEADING  (1'b1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .signal      (signal),
    .period      (period),
    .period_load (period_load),
    .segments    (segments),
    .digit_sel   (digit_sel),
    .overflow    (overflow),
    .valid       (valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    bit         reload;
    int         per;
    int         n_edges;
    int         hi;
    int         lo;
    logic [6:0] e0;
    logic [6:0] e1;
    logic [6:0] e2;
    logic       ov;
  } vec_t;

  vec_t vecs [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic load_period(input int p, output int lcyc);
    period      = PERIOD_BITS'(p);
    period_load = 1'b1;
    tick();
    period_load = 1'b0;
    lcyc        = cyc;
  endtask

  // The last edge skips its low phase so the burst never reaches the window end.
  task automatic gen_edges(input int n, input int hi, input int lo);
    for (int k = 0; k < n; k++) begin
      signal = 1'b1;
      repeat (hi) tick();
      signal = 1'b0;
      if (k != n - 1) repeat (lo) tick();
    end
  endtask

  task automatic wait_valid(input int bound, output int vcyc);
    vcyc = -1;
    for (int k = 0; k < bound; k++) begin
      tick();
      if (valid === 1'b1) begin
        vcyc = cyc;
        break;
      end
    end
  endtask

  task automatic check_display(input string name, input logic [6:0] e0,
                               input logic [6:0] e1, input logic [6:0] e2);
    logic [6:0] s0, s1, s2;
    s0 = 'x;
    s1 = 'x;
    s2 = 'x;
    repeat (2) tick();
    repeat (3 * SCAN_CYCLES) begin
      case (digit_sel)
        3'b001:  s0 = segments;
        3'b010:  s1 = segments;
        3'b100:  s2 = segments;
        default: ;
      endcase
      tick();
    end
    check({name, "_d0"}, 32'(s0), 32'(e0));
    check({name, "_d1"}, 32'(s1), 32'(e1));
    check({name, "_d2"}, 32'(s2), 32'(e2));
  endtask

  initial begin
    int l, v, last_v, ref_cyc, rst_cyc;

    // reload, period, edges, high clocks, low clocks, digit0/1/2 segments, overflow
    vecs[0] = '{1'b1,  100,   25, 2, 2, 7'h6D, 7'h5B, 7'h00, 1'b0};  // 25
    vecs[1] = '{1'b1,  100,    0, 2, 2, 7'h3F, 7'h00, 7'h00, 1'b0};  // 0
    vecs[2] = '{1'b1,  200,   10, 2, 2, 7'h3F, 7'h06, 7'h00, 1'b0};  // 10
    vecs[3] = '{1'b1,  400,  100, 1, 2, 7'h3F, 7'h3F, 7'h06, 1'b0};  // 100
    vecs[4] = '{1'b1,  200,    9, 1, 1, 7'h6F, 7'h00, 7'h00, 1'b0};  // 9
    vecs[5] = '{1'b1, 4000, 1990, 1, 1, 7'h6F, 7'h6F, 7'h6F, 1'b1};  // saturates at 999
    vecs[6] = '{1'b0, 4000,    7, 2, 2, 7'h07, 7'h00, 7'h00, 1'b0};  // 7, next window

    // Reset held for three clocks with the pin toggling, then the first free cycle.
    for (int k = 0; k < 3; k++) begin
      signal = ~signal;
      tick();
      check($sformatf("reset%0d_digit_sel", k), 32'(digit_sel), 32'h1);
      check($sformatf("reset%0d_segments", k),  32'(segments),  32'h3F);
      check($sformatf("reset%0d_overflow", k),  32'(overflow),  32'h0);
      check($sformatf("reset%0d_valid", k),     32'(valid),     32'h0);
    end
    reset  = 1'b0;
    signal = 1'b0;
    tick();
    check("release_digit_sel", 32'(digit_sel), 32'h1);
    check("release_segments",  32'(segments),  32'h3F);
    check("release_overflow",  32'(overflow),  32'h0);
    check("release_valid",     32'(valid),     32'h0);

    last_v = 0;
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].reload) load_period(vecs[i].per, ref_cyc);
      else ref_cyc = last_v;
      gen_edges(vecs[i].n_edges, vecs[i].hi, vecs[i].lo);
      wait_valid(vecs[i].per + 20, v);
      check($sformatf("vec%0d_interval", i), 32'(v - ref_cyc), 32'(vecs[i].per));
      check($sformatf("vec%0d_overflow", i), 32'(overflow), 32'(vecs[i].ov));
      tick();
      check($sformatf("vec%0d_valid_pulse", i), 32'(valid), 32'h0);
      check_display($sformatf("vec%0d", i), vecs[i].e0, vecs[i].e1, vecs[i].e2);
      last_v = v;
    end

    // Detect pulse lands in the TC cycle (gate_cnt = 19): counted now, not next window.
    load_period(20, l);
    repeat (17) tick();
    signal = 1'b1;
    repeat (2) tick();
    signal = 1'b0;
    wait_valid(40, v);
    check("tc_interval", 32'(v - l), 32'd20);
    check_display("tc_closing", 7'h06, 7'h00, 7'h00);
    last_v = v;
    wait_valid(40, v);
    check("tc_next_interval", 32'(v - last_v), 32'd20);
    check_display("tc_next", 7'h3F, 7'h00, 7'h00);

    // Load 50 at gate_cnt = 30 after five discarded edges; display keeps 12.
    load_period(100, l);
    gen_edges(12, 2, 2);
    wait_valid(120, v);
    check("mw_first_interval", 32'(v - l), 32'd100);
    gen_edges(5, 2, 2);
    repeat (12) tick();
    load_period(50, l);
    check_display("mw_hold", 7'h5B, 7'h06, 7'h00);
    wait_valid(60, v);
    check("mw_interval", 32'(v - l), 32'd50);
    check_display("mw_after", 7'h3F, 7'h00, 7'h00);

    // Period 0 clamps to 2; a load in the TC cycle suppresses that valid.
    load_period(0, l);
    wait_valid(10, v);
    check("clamp_interval", 32'(v - l), 32'd2);
    last_v = v;
    wait_valid(10, v);
    check("clamp_interval2", 32'(v - last_v), 32'd2);
    tick();
    load_period(0, l);
    check("load_on_tc_valid", 32'(valid), 32'h0);
    wait_valid(10, v);
    check("load_on_tc_interval", 32'(v - l), 32'd2);

    // Reset at gate_cnt = 60 with 12 counted; valid comes DEFAULT_PERIOD+1 clocks
    // after the cycle in which reset is raised, showing only the 3 later edges.
    load_period(100, l);
    gen_edges(12, 2, 2);
    repeat (14) tick();
    reset   = 1'b1;
    rst_cyc = cyc;
    tick();
    reset   = 1'b0;
    check("rst_valid",     32'(valid),     32'h0);
    check("rst_segments",  32'(segments),  32'h3F);
    check("rst_digit_sel", 32'(digit_sel), 32'h1);
    gen_edges(3, 2, 2);
    wait_valid(DEFAULT_PERIOD + 20, v);
    check("rst_interval", 32'(v - rst_cyc), 32'(DEFAULT_PERIOD + 1));
    check("rst_overflow", 32'(overflow), 32'h0);
    check_display("rst_count", 7'h4F, 7'h00, 7'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_frequency_counter.md
# bcd_frequency_counter

Parametrised gated frequency counter with an N-digit multiplexed seven-segment display. It counts rising edges of an asynchronous input over a runtime-loadable window of clock cycles, accumulating directly in cascaded BCD digits with saturation and an overflow flag. At each window end it latches the result into a display register and scans the digits one at a time onto a shared segment bus. It sits between the raw `signal` pin and the board's common-cathode display, and supersedes the fixed 2-digit, fixed-period counter.

## Interface
- `DIGITS`, 3: number of BCD digits counted and displayed (1..6).
- `PERIOD_BITS`, 16: width of the gate-period register.
- `DEFAULT_PERIOD`, 1200: gate period in clocks after reset.
- `SCAN_CYCLES`, 64: clocks each digit is shown before the scan advances (≥1).
- `BLANK_LEADING`, 1: if 1, leading zero digits are blanked; the least-significant digit is never blanked.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `signal` in 1: asynchronous input whose frequency is measured.
- `period` in PERIOD_BITS: new gate period, in clocks.
- `period_load` in 1: single-cycle strobe that loads `period`.
- `segments` out 7: active-high segments, bit0=a … bit6=g, for the currently selected digit.
- `digit_sel` out DIGITS: one-hot digit enable; bit 0 is the least-significant digit.
- `overflow` out 1: the last completed window saturated.
- `valid` out 1: one-cycle pulse when the display register updates.

## Operation
- **Input path**
  - `signal` passes through a 2-flop synchroniser, then a third register.
  - A detect pulse is raised when sync2=1 and the third register is 0.
  - One pulse per rising edge; high time or low time under 1 clock is not guaranteed to be seen.
- **Gate counter**
  - `gate_cnt` runs 0 .. `period_reg`-1, then wraps to 0. This is the terminal cycle (TC).
  - `period_reg` resets to `DEFAULT_PERIOD`.
  - A loaded value below 2 is clamped to 2.
- **BCD accumulator**
  - `DIGITS` 4-bit digits; a detect pulse increments digit 0 with decimal carry.
  - When all digits are 9, further pulses are ignored and the `sat` flag is set.
  - No binary-to-BCD conversion state is used.
- **Terminal cycle, in one clock**
  - The display register takes the accumulator value, including any pulse detected in the TC cycle itself.
  - `overflow` takes `sat`, including any saturation in that cycle.
  - `valid` pulses.
  - Accumulator and `sat` clear to 0.
- **period_load**
  - `period_reg` takes `period` (clamped).
  - `gate_cnt`, the accumulator and `sat` clear.
  - The display register, `overflow` and `valid` are untouched; the partial window is discarded.
  - If `period_load` coincides with TC, the load wins and no `valid` is produced.
- **Scanner**
  - `scan_cnt` counts 0 .. `SCAN_CYCLES`-1.
  - At wrap, `digit_sel` rotates left, and from the MSB back to bit 0.
  - `segments` is the decode of the display digit selected by `digit_sel`, registered.
  - A digit is blanked (`segments`=0) when `BLANK_LEADING`=1, it is not digit 0, and it and every more-significant digit are 0.
- **Reset values**
  - Synchronizer, accumulator, `sat`, display register, `gate_cnt`, `scan_cnt`: 0.
  - `period_reg`: `DEFAULT_PERIOD`.
  - Outputs: `digit_sel`=1, `segments`=7'h3F (digit 0 shows "0"), `overflow`=0, `valid`=0.

## Timing
- Pin rising edge to detect pulse: 2–3 clocks.
- A window is exactly `period_reg` clocks, back-to-back with no dead cycles.
- `valid`, the new display value and `overflow` appear the cycle after TC.
- Display register to `segments`: 1 clock, registered decode.
- `digit_sel` and `segments` change in the same cycle; there is no ghosting cycle.
- Reset asserted mid-window or mid-scan aborts everything next edge; the first window after reset starts with `gate_cnt`=0.

## Structure
- Package `freq_counter_pkg`:
  - seven-segment encoding constants for 0–9 (7'h3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F) and `SEG_BLANK`=0;
  - BCD digit typedef (4 bits);
  - the period clamp minimum (2).
- Sub-module `segment_scanner`:
  - parameters `DIGITS`, `SCAN_CYCLES`, `BLANK_LEADING`;
  - input: flattened display digits;
  - outputs: `segments`, `digit_sel`;
  - owns `scan_cnt`, rotation, blanking and decode.
- The top holds the synchroniser, gate counter, BCD accumulator and display register.

## Test plan
All scenarios use `DIGITS`=3, `SCAN_CYCLES`=4, `BLANK_LEADING`=1.
- **Reset:** check outputs.
  - Assert reset for 3 clocks with `signal` toggling.
  - Required: `digit_sel`=3'b001, `segments`=7'h3F, `overflow`=0, `valid`=0 throughout and in the first cycle after release.
- **Basic count:**
  - Load period=100, drive 25 rising edges spaced 4 clocks apart inside one window.
  - Required: one `valid` per 100 clocks. Scan shows digit0=7'h6D ("5"), digit1=7'h5B ("2"), digit2 blanked (0). `overflow`=0.
- **Saturation:**
  - Period=4000, `signal` toggling every clock, giving about 2000 edges.
  - Required: display 999 (all digits 7'h6F), `overflow`=1.
  - A following window with 7 edges gives display 7 with digits 1–2 blank, and `overflow`=0.
- **Edge on TC:**
  - Place a detect pulse exactly in the TC cycle.
  - Required: it is counted in the closing window, and the next window starts from 0.
- **period_load mid-window and clamp:**
  - Load 50 at `gate_cnt`=30.
  - Required: no `valid` until 50 clocks later, and the display holds its old value until then.
  - Load 0: `valid` every 2 clocks.
  - Load coincident with TC: that `valid` is suppressed.
- **Reset mid-operation:**
  - Assert reset at `gate_cnt`=60 with accumulator=12.
  - Required: after release, the next `valid` occurs exactly `DEFAULT_PERIOD`+1 clocks later, showing only post-reset edges.
